seg7_scan: RTL and testbench

Parametrised, bus-mapped, time-multiplexed seven-segment display controller. It holds one hex nibble per digit and continuously scans up to eight digits, driving one digit select at a time with the decoded segment pattern. Per-digit enable and decimal-point masks are supported, and all registers can be read back. It sits on the peripheral bus beside the other memory-mapped drivers, and its data_out feeds the read arbiter.

---
 rtl/seg7_scan.sv | 202 ++++++++++++++++++++
 tb/tb_seg7_scan.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: bus-mapped, time-multiplexed seven-segment display controller.
//
// Holds one hex nibble per digit and scans up to eight digits. Only one
// digit select is active at a time, and it carries the decoded segment
// pattern. Per-digit enable and decimal-point masks are supported, and all
// registers can be read back over the peripheral bus.
//
// Register map (byte addresses relative to BASE_ADDR):
//   +0 DATA   R/W  nibble i at [4i+3:4i] is the hex value of digit i
//   +4 CTRL   R/W  [7:0] digit enable, [15:8] DP mask, [16] scan_en
//   +8 STATUS RO   [2:0] current scan index
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   addr         bus address
//   en           bus access enable
//   byte_sel     byte-lane write enables (lane k = data_in[8k+7:8k])
//   data_in      write data
//   we           write enable (0 = read)
//   data_out     combinational read data, 0 when not addressed
//   sel_out      registered digit selects, bit i selects digit i
//   digital_out  registered segments {DP,G,F,E,D,C,B,A}
module seg7_scan #(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned CLK_DIV    = 50000,
  parameter logic [31:0] BASE_ADDR  = 32'hfffffc00,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic              en,
  input  logic [3:0]        byte_sel,
  input  logic [31:0]       data_in,
  input  logic              we,
  output logic [31:0]       data_out,
  output logic [DIGITS-1:0] sel_out,
  output logic [7:0]        digital_out
);

  localparam int unsigned SEL_W = DIGITS;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Writable/readable bits: only nibbles and mask bits of existing digits.
  localparam logic [63:0] ONE64     = 64'd1;
  localparam logic [31:0] DATA_MASK = 32'((ONE64 << (4 * DIGITS)) - ONE64);
  localparam logic [7:0]  DIG_MASK  = 8'((ONE64 << DIGITS) - ONE64);
  localparam logic [31:0] CTRL_MASK = {15'd0, 1'b1, DIG_MASK, DIG_MASK};
  localparam logic [31:0] CTRL_RST  = {15'd0, 1'b1, 8'd0, DIG_MASK};

  localparam logic [31:0] ADDR_DATA = BASE_ADDR;
  localparam logic [31:0] ADDR_CTRL = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_STAT = BASE_ADDR + 32'd8;

  // Idle output levels and the polarity flip applied to the active-low form.
  localparam logic [SEL_W-1:0] SEL_IDLE = {SEL_W{ACTIVE_LOW}};
  localparam logic [7:0]       SEG_IDLE = {8{ACTIVE_LOW}};
  localparam logic [SEL_W-1:0] SEL_FLIP = {SEL_W{~ACTIVE_LOW}};
  localparam logic [7:0]       SEG_FLIP = {8{~ACTIVE_LOW}};
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

  // Hex to active-low segment pattern {DP,G,F,E,D,C,B,A}, DP off.
  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    logic [7:0] s;
    s = 8'hff;
    case (v)
      4'h0: s = 8'hc0;
      4'h1: s = 8'hf9;
      4'h2: s = 8'ha4;
      4'h3: s = 8'hb0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hf8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'ha: s = 8'h88;
      4'hb: s = 8'h83;
      4'hc: s = 8'hc6;
      4'hd: s = 8'ha1;
      4'he: s = 8'h86;
      4'hf: s = 8'h8e;
      default: s = 8'hff;
    endcase
    return s;
  endfunction

  // State registers
  logic [31:0]      data_q;
  logic [31:0]      ctrl_q;
  logic [DIV_W-1:0] div_q;
  logic [IDX_W-1:0] idx_q;

  // Next-state values
  logic [31:0]      data_d;
  logic [31:0]      ctrl_d;
  logic [DIV_W-1:0] div_d;
  logic [IDX_W-1:0] idx_d;

  // Bus decode
  logic        wr_c;
  logic        rd_c;
  logic [31:0] lane_mask_c;

  // Output composition
  logic [3:0]       nib_c;
  logic [7:0]       ena_c;
  logic [7:0]       dp_mask_c;
  logic             lit_c;
  logic             dp_c;
  logic [7:0]       seg_low_c;
  logic [SEL_W-1:0] sel_low_c;

  assign wr_c        = en & we;
  assign rd_c        = en & ~we & ~rst;
  assign lane_mask_c = {{8{byte_sel[3]}}, {8{byte_sel[2]}},
                        {8{byte_sel[1]}}, {8{byte_sel[0]}}};

  // Register writes: byte-lane merge, then drop bits of absent digits.
  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (wr_c) begin
      if (addr == ADDR_DATA) begin
        data_d = ((data_q & ~lane_mask_c) | (data_in & lane_mask_c)) & DATA_MASK;
      end
      if (addr == ADDR_CTRL) begin
        ctrl_d = ((ctrl_q & ~lane_mask_c) | (data_in & lane_mask_c)) & CTRL_MASK;
      end
    end
  end

  // Scan divider and index. Counting needs scan_en both before and after
  // this edge, so a 0->1 transition starts at divider 0 and digit 0, and a
  // write clearing scan_en zeroes the index on the same edge.
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (!(ctrl_q[16] && ctrl_d[16])) begin
      div_d = '0;
      idx_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Segment/select pattern for the current digit, in active-low form.
  always_comb begin
    ena_c     = ctrl_q[7:0];
    dp_mask_c = ctrl_q[15:8];
    nib_c     = data_q[{idx_q, 2'b00} +: 4];
    lit_c     = ctrl_q[16] & ena_c[idx_q];
    dp_c      = dp_mask_c[idx_q];
    seg_low_c = 8'hff;
    sel_low_c = '1;
    if (lit_c) begin
      seg_low_c = seg_decode(nib_c) & {~dp_c, 7'h7f};
      sel_low_c = ~(SEL_ONE << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      ctrl_q      <= CTRL_RST;
      div_q       <= '0;
      idx_q       <= '0;
      sel_out     <= SEL_IDLE;
      digital_out <= SEG_IDLE;
    end else begin
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      sel_out     <= sel_low_c ^ SEL_FLIP;
      digital_out <= seg_low_c ^ SEG_FLIP;
    end
  end

  // Combinational read-back; zero whenever not addressed or in reset.
  always_comb begin
    data_out = '0;
    if (rd_c) begin
      if (addr == ADDR_DATA) begin
        data_out = data_q;
      end else if (addr == ADDR_CTRL) begin
        data_out = ctrl_q;
      end else if (addr == ADDR_STAT) begin
        data_out = {29'd0, idx_q};
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized + directed bench for seg7_scan (DIGITS=4,
// CLK_DIV=4, ACTIVE_LOW=1) against a register/elapsed-time reference model.
module tb_seg7_scan;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned CLK_DIV = 4;
  localparam logic [31:0] BASE    = 32'hfffffc00;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        en;
  logic [3:0]  byte_sel;
  logic [31:0] data_in;
  logic        we;
  logic [31:0] data_out;
  logic [3:0]  sel_out;
  logic [7:0]  digital_out;

  seg7_scan #(
    .DIGITS    (DIGITS),
    .CLK_DIV   (CLK_DIV),
    .BASE_ADDR (BASE),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .en         (en),
    .byte_sel   (byte_sel),
    .data_in    (data_in),
    .we         (we),
    .data_out   (data_out),
    .sel_out    (sel_out),
    .digital_out(digital_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: register contents as per-digit fields, and the scan
  // position as cycles elapsed since the scan was (re)started.
  logic [7:0] seg_tab [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};
  logic [3:0] m_data [DIGITS];
  bit         m_ena  [DIGITS];
  bit         m_dp   [DIGITS];
  bit         m_scan;
  int         m_t;
  logic [3:0] exp_sel;
  logic [7:0] exp_seg;

  function automatic int model_idx();
    return m_scan ? (m_t / CLK_DIV) % DIGITS : 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a == BASE) begin
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = m_data[i];
    end else if (a == BASE + 32'd4) begin
      for (int i = 0; i < DIGITS; i++) begin
        r[i]     = m_ena[i];
        r[8 + i] = m_dp[i];
      end
      r[16] = m_scan;
    end else if (a == BASE + 32'd8) begin
      r[2:0] = 3'(model_idx());
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) begin
      m_data[i] = 4'h0;
      m_ena[i]  = 1'b1;
      m_dp[i]   = 1'b0;
    end
    m_scan  = 1'b1;
    m_t     = 0;
    exp_sel = 4'hf;
    exp_seg = 8'hff;
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_edge();
    int         idx;
    bit         old_scan;
    logic [3:0] one_hot;
    if (rst) begin
      model_reset();
      return;
    end
    idx = model_idx();
    if (m_scan && m_ena[idx]) begin
      one_hot      = 4'h0;
      one_hot[idx] = 1'b1;
      exp_sel      = ~one_hot;
      exp_seg      = seg_tab[m_data[idx]];
      if (m_dp[idx]) exp_seg[7] = 1'b0;
    end else begin
      exp_sel = 4'hf;
      exp_seg = 8'hff;
    end
    old_scan = m_scan;
    if (en && we) begin
      if (addr == BASE) begin
        for (int n = 0; n < DIGITS; n++)
          if (byte_sel[n / 2]) m_data[n] = data_in[4*n +: 4];
      end else if (addr == BASE + 32'd4) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (byte_sel[0]) m_ena[i] = data_in[i];
          if (byte_sel[1]) m_dp[i]  = data_in[8 + i];
        end
        if (byte_sel[2]) m_scan = data_in[16];
      end
    end
    m_t = (old_scan && m_scan) ? m_t + 1 : 0;
  endtask

  // One clock: check read data mid-cycle, step the model, check outputs after the edge.
  task automatic tick(input string tag);
    #1;
    if (!rst && en && !we) check({tag, "_rd"}, data_out, model_read(addr));
    else                   check({tag, "_dout0"}, data_out, 32'h0);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, "_sel"}, 32'(sel_out), 32'(exp_sel));
    check({tag, "_seg"}, 32'(digital_out), 32'(exp_seg));
  endtask

  task automatic bus_idle();
    en = 1'b0; we = 1'b0; addr = 32'h0; byte_sel = 4'h0; data_in = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bs);
    en = 1'b1; we = 1'b1; addr = a; data_in = d; byte_sel = bs;
    tick("wr");
    bus_idle();
  endtask

  task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    en = 1'b1; we = 1'b0; addr = a; byte_sel = 4'h0;
    #1;
    check(tag, data_out, exp);
    tick(tag);
    bus_idle();
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    int          r;
    logic [31:0] a;
    logic [31:0] d;

    bus_idle();
    rst = 1'b1;
    model_reset();
    tick("rst");
    check("rst_sel_const", 32'(sel_out), 32'h0000000f);
    check("rst_seg_const", 32'(digital_out), 32'h000000ff);
    rst = 1'b0;

    rd_expect("ctrl_rst", BASE + 32'd4, 32'h0001000f);

    wr(BASE, 32'h00003210, 4'b0011);
    rd_expect("data_3210", BASE, 32'h00003210);
    run("frame0", 2 * DIGITS * CLK_DIV);

    wr(BASE, 32'hffffffff, 4'b0001);
    rd_expect("data_lane0", BASE, 32'h000032ff);
    run("frame1", DIGITS * CLK_DIV);

    wr(BASE + 32'd4, 32'h00010205, 4'hf);
    run("mask5", DIGITS * CLK_DIV);
    wr(BASE + 32'd4, 32'h00010207, 4'hf);
    run("mask7", DIGITS * CLK_DIV + 3);

    wr(BASE + 32'd4, 32'h00000000, 4'hf);
    rd_expect("stat_off", BASE + 32'd8, 32'h0);
    run("off", 3);
    check("off_sel_const", 32'(sel_out), 32'h0000000f);
    wr(BASE + 32'd4, 32'h0001000f, 4'hf);
    run("reen", DIGITS * CLK_DIV + 2);

    // Reset mid-frame, first alone, then racing a STATUS write and a DATA write.
    wr(BASE, 32'h0000abcd, 4'hf);
    run("pre_rst", 5);
    rst = 1'b1;
    tick("rst_mid");
    rst = 1'b0;
    wr(BASE, 32'h0000abcd, 4'hf);
    run("pre_rst2", 6);
    en = 1'b1; we = 1'b1; addr = BASE + 32'd8; data_in = 32'hffffffff; byte_sel = 4'hf;
    rst = 1'b1;
    tick("rst_wr_stat");
    addr = BASE; data_in = 32'h12345678;
    tick("rst_wr_data");
    rst = 1'b0;
    bus_idle();
    rd_expect("data_after_rst", BASE, 32'h0);
    rd_expect("ctrl_after_rst", BASE + 32'd4, 32'h0001000f);
    wr(BASE + 32'd12, 32'hffffffff, 4'hf);
    rd_expect("unmapped", BASE + 32'd12, 32'h0);
    wr(BASE + 32'd8, 32'hffffffff, 4'hf);
    run("post_stat_wr", 3);

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1;
        tick("rnd_rst");
        rst = 1'b0;
      end else if (r < 30) begin
        case ($urandom_range(0, 4))
          0: a = BASE;
          1: a = BASE + 32'd4;
          2: a = BASE + 32'd8;
          3: a = BASE + 32'd12;
          default: a = $urandom;
        endcase
        d = $urandom;
        if (a == BASE + 32'd4 && $urandom_range(0, 9) < 8) d[16] = 1'b1;
        wr(a, d, 4'($urandom));
      end else if (r < 60) begin
        case ($urandom_range(0, 3))
          0: a = BASE;
          1: a = BASE + 32'd4;
          2: a = BASE + 32'd8;
          default: a = BASE + 32'd12;
        endcase
        en = 1'b1; we = 1'b0; addr = a; byte_sel = 4'($urandom);
        tick("rnd_rd");
        bus_idle();
      end else begin
        tick("rnd_idle");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
